// File: rtl/ahb_fabric_pkg.sv
// Shared definitions for the single-master AHB-Lite fabric.
// Holds the address map, the transfer FSM states and the HRESP encodings.
// Entries beyond NSLV in the map are simply not decoded.
package ahb_fabric_pkg;

  localparam int MAX_SLV = 8;

  // Slave i is hit when (HADDR & MASK[i]) == BASE[i]; lower index wins.
  localparam logic [31:0] BASE [MAX_SLV] = '{
    32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'h5000_0000,
    32'h6000_0000, 32'h7000_0000, 32'hA000_0000, 32'hB000_0000
  };
  localparam logic [31:0] MASK [MAX_SLV] = '{
    32'hF000_0000, 32'hFFFF_F000, 32'hF000_0000, 32'hF000_0000,
    32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_fabric_if.sv
// Bus bundle between the master, the fabric and the NSLV slaves.
// The slave modport is the fabric's view (it is the slave of the master);
// the master modport is the surrounding environment's view.
interface ahb_fabric_if #(
  parameter int NSLV = 4
);
  logic                 HREQUEST;
  logic [31:0]          HADDR;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [31:0]          HRDATA;
  logic                 HREADY;
  logic                 HRESP;
  logic [NSLV-1:0]      HSEL_S;
  logic                 HREADY_S;
  logic [NSLV-1:0]      HREADYOUT_S;
  logic [NSLV-1:0]      HRESP_S;
  logic [NSLV-1:0][31:0] HRDATA_S;

  modport slave (
    input  HREQUEST, HADDR, HWRITE, HSIZE, HREADYOUT_S, HRESP_S, HRDATA_S,
    output HRDATA, HREADY, HRESP, HSEL_S, HREADY_S
  );

  modport master (
    output HREQUEST, HADDR, HWRITE, HSIZE, HREADYOUT_S, HRESP_S, HRDATA_S,
    input  HRDATA, HREADY, HRESP, HSEL_S, HREADY_S
  );

endinterface

// File: rtl/ahb_fabric_decoder.sv
// Address decoder: HADDR to one-hot slave hit plus a miss flag.
// Purely combinational, zero latency.
// No backpressure; the caller qualifies the result with the request.
module ahb_fabric_decoder
  import ahb_fabric_pkg::*;
#(
  parameter int NSLV = 4
) (
  input  logic [31:0]     haddr,
  output logic [NSLV-1:0] hit,
  output logic            miss
);

  // Scan from the top so the lowest matching index is the one that sticks.
  always_comb begin
    hit  = '0;
    miss = 1'b1;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((haddr & MASK[i]) == BASE[i]) begin
        hit    = '0;
        hit[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_fabric.sv
// Single-master AHB-Lite fabric: decode, data-phase mux, default slave, wait timeout.
// One-cycle address-to-data pipeline; two-cycle ERROR on unmapped or timed-out transfers.
// The selected slave's HREADYOUT stalls the master; the fabric stalls only during ERR1.
module ahb_lite_fabric
  import ahb_fabric_pkg::*;
#(
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  ahb_fabric_if.slave bus,
  output logic        err_valid,
  output logic [31:0] err_addr,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam int SW   = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int TOW  = $clog2(TIMEOUT + 1);
  localparam int CW   = (TOW > 8) ? TOW : 8;
  // Last wait cycle index; the transfer aborts when this wait cycle is seen.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [SW-1:0]   sel_d, sel_nxt, hit_idx;
  logic [31:0]     addr_d, addr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [NSLV-1:0] hit;
  logic            miss;
  logic            hready, hresp;
  logic [31:0]     hrdata;
  logic            can_load;
  logic            fault, fault_to;
  logic [31:0]     fault_addr;

  ahb_fabric_decoder #(.NSLV(NSLV)) u_dec (
    .haddr (bus.HADDR),
    .hit   (hit),
    .miss  (miss)
  );

  assign bus.HSEL_S   = hit & {NSLV{bus.HREQUEST}};
  assign bus.HREADY   = hready;
  assign bus.HREADY_S = hready;
  assign bus.HRESP    = hresp;
  assign bus.HRDATA   = hrdata;

  // One-hot hit to binary slave index for the data-phase mux.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (hit[i]) hit_idx = SW'(i);
    end
  end

  // Transfer FSM: next state, master-side response and fault detection.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel_d;
    addr_nxt   = addr_d;
    cnt_nxt    = cnt;
    hready     = 1'b1;
    hresp      = RESP_OKAY;
    hrdata     = '0;
    can_load   = 1'b0;
    fault      = 1'b0;
    fault_to   = 1'b0;
    fault_addr = addr_d;
    case (state)
      IDLE: can_load = 1'b1;
      DATA: begin
        hready = bus.HREADYOUT_S[sel_d];
        hresp  = bus.HRESP_S[sel_d];
        hrdata = bus.HRDATA_S[sel_d];
        if (hready) begin
          can_load = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
            state_nxt = ERR1;
            fault     = 1'b1;
            fault_to  = 1'b1;
          end
        end
      end
      ERR1: begin
        hready    = 1'b0;
        hresp     = RESP_ERROR;
        state_nxt = ERR2;
      end
      ERR2: begin
        hresp    = RESP_ERROR;
        can_load = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    // Address phase completes whenever HREADY is high; a request reloads, else idle.
    if (can_load) begin
      state_nxt = IDLE;
      if (bus.HREQUEST) begin
        addr_nxt = bus.HADDR;
        cnt_nxt  = '0;
        if (miss) begin
          state_nxt  = ERR1;
          sel_nxt    = '0;
          fault      = 1'b1;
          fault_addr = bus.HADDR;
        end else begin
          state_nxt = DATA;
          sel_nxt   = hit_idx;
        end
      end
    end
  end

  // FSM and data-phase context registers.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state  <= IDLE;
      sel_d  <= '0;
      addr_d <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      sel_d  <= sel_nxt;
      addr_d <= addr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Sticky fault record: first fault kept; a fault beats a same-cycle clear.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      err_valid   <= 1'b0;
      err_addr    <= '0;
      err_timeout <= 1'b0;
    end else if (fault) begin
      err_valid <= 1'b1;
      if (!err_valid || err_clr) begin
        err_addr    <= fault_addr;
        err_timeout <= fault_to;
      end
    end else if (err_clr) begin
      err_valid   <= 1'b0;
      err_addr    <= '0;
      err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_lite_fabric.sv
// Bench for ahb_lite_fabric: master driver, behavioural slaves, scoreboard.
// Expected responses are queued at address-phase acceptance and checked at data-phase completion.
// Sticky error record and reset behaviour are checked directly.
module tb_ahb_lite_fabric;

  localparam int NSLV = 4;
  localparam int TO   = 4;

  typedef struct {
    logic [31:0] data;
    logic        resp;
    int          waits;
  } exp_t;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_timeout;
  logic        err_clr;

  ahb_fabric_if #(.NSLV(NSLV)) bus ();

  ahb_lite_fabric #(.NSLV(NSLV), .TIMEOUT(TO)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .bus         (bus),
    .err_valid   (err_valid),
    .err_addr    (err_addr),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
    end
  endtask

  // Reference address map.
  function automatic int tb_decode(input logic [31:0] a);
    if (a[31:28] == 4'h0)          return 0;
    if (a[31:12] == 20'h20000)     return 1;
    if (a[31:28] == 4'h4)          return 2;
    if (a[31:28] == 4'h5)          return 3;
    return -1;
  endfunction

  // Slave behaviour configuration.
  logic [31:0] sdata  [NSLV];
  int          swaits [NSLV];
  bit          snever [NSLV];

  // Slave model: address phase captured mid-cycle, response driven just after the edge.
  logic            ap_take;
  logic [NSLV-1:0] ap_sel;
  int              act_s = -1;
  int              wcnt  = 0;

  always @(negedge HCLK) begin
    ap_take = bus.HREADY;
    ap_sel  = bus.HSEL_S;
  end

  always @(posedge HCLK) begin
    #1;
    if (HRESET) begin
      act_s = -1;
    end else begin
      if (ap_take) act_s = -1;
      else if (act_s >= 0 && wcnt > 0) wcnt--;
      if (ap_take && ap_sel != '0) begin
        for (int i = 0; i < NSLV; i++) if (ap_sel[i]) act_s = i;
        wcnt = swaits[act_s];
      end
    end
    for (int i = 0; i < NSLV; i++) begin
      bus.HREADYOUT_S[i] = 1'b1;
      bus.HRESP_S[i]     = 1'b0;
      bus.HRDATA_S[i]    = 32'h0;
    end
    if (act_s >= 0) begin
      bus.HREADYOUT_S[act_s] = !snever[act_s] && (wcnt == 0);
      bus.HRDATA_S[act_s]    = bus.HREADYOUT_S[act_s] ? sdata[act_s] : 32'h0;
    end
  end

  // Scoreboard monitor.
  exp_t sb[$];
  bit   pending = 0;
  int   lowcnt  = 0;

  always @(negedge HCLK) begin
    exp_t            e;
    int              idx;
    logic [NSLV-1:0] es;
    if (HRESET) begin
      sb.delete();
      pending = 0;
      lowcnt  = 0;
    end else begin
      if (pending) begin
        if (!bus.HREADY) begin
          if (sb[0].resp && lowcnt == sb[0].waits - 1) chk("err1_hresp", bus.HRESP, 1'b1);
          lowcnt++;
        end else begin
          e = sb.pop_front();
          chk("hrdata", bus.HRDATA, e.data);
          chk("hresp", bus.HRESP, e.resp);
          chk("wait_cycles", lowcnt, e.waits);
          pending = 0;
          lowcnt  = 0;
        end
      end
      if (bus.HREQUEST && bus.HREADY) begin
        idx = tb_decode(bus.HADDR);
        es  = '0;
        if (idx >= 0) es[idx] = 1'b1;
        chk("hsel", 32'(bus.HSEL_S), 32'(es));
        if (idx < 0) begin
          e.data = 32'h0; e.resp = 1'b1; e.waits = 1;
        end else if (snever[idx]) begin
          e.data = 32'h0; e.resp = 1'b1; e.waits = TO + 1;
        end else begin
          e.data = sdata[idx]; e.resp = 1'b0; e.waits = swaits[idx];
        end
        sb.push_back(e);
        pending = 1;
      end
    end
  end

  // Master driver; called and returns at posedge+1.
  task automatic issue(input logic [31:0] a);
    bus.HREQUEST = 1'b1;
    bus.HADDR    = a;
    bus.HWRITE   = 1'b0;
    bus.HSIZE    = 3'd2;
    for (int n = 0; n < 60; n++) begin
      @(negedge HCLK);
      if (bus.HREADY) break;
      if (n == 59) chk("accept_bound", 32'd0, 32'd1);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic drain();
    bus.HREQUEST = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge HCLK); #1;
      if (!pending && sb.size() == 0) break;
      if (n == 59) chk("drain_bound", 32'd0, 32'd1);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge HCLK); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    HRESET       = 1'b1;
    err_clr      = 1'b0;
    bus.HREQUEST = 1'b0;
    bus.HADDR    = 32'h0;
    bus.HWRITE   = 1'b0;
    bus.HSIZE    = 3'd2;
    for (int i = 0; i < NSLV; i++) begin
      sdata[i] = 32'hA000_0000 + i; swaits[i] = 0; snever[i] = 0;
    end
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_hready", bus.HREADY, 1'b1);
    chk("rst_hresp", bus.HRESP, 1'b0);
    chk("rst_hrdata", bus.HRDATA, 32'h0);
    chk("rst_err_valid", err_valid, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    chk("rst_err_timeout", err_timeout, 1'b0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Zero-wait read from slave1.
    sdata[1] = 32'hDEAD_BEEF;
    issue(32'h2000_0010);
    drain();
    chk("no_fault_ok", err_valid, 1'b0);

    // Back-to-back: slave0 with 2 waits, then slave1.
    swaits[0] = 2; sdata[0] = 32'h1111_0000;
    issue(32'h0000_0100);
    issue(32'h2000_0020);
    drain();
    swaits[0] = 0;

    // Unmapped access.
    issue(32'h9000_0000);
    drain();
    chk("miss_err_valid", err_valid, 1'b1);
    chk("miss_err_addr", err_addr, 32'h9000_0000);
    chk("miss_err_timeout", err_timeout, 1'b0);
    pulse_clr();
    chk("clr_err_valid", err_valid, 1'b0);
    chk("clr_err_addr", err_addr, 32'h0);

    // Just under the timeout.
    swaits[1] = 3; sdata[1] = 32'h0BAD_CAFE;
    issue(32'h2000_0044);
    drain();
    chk("slow_ok_no_fault", err_valid, 1'b0);
    swaits[1] = 0;

    // Timeout, then a second fault keeps the first record.
    snever[1] = 1;
    issue(32'h2000_0040);
    drain();
    snever[1] = 0;
    chk("to_err_valid", err_valid, 1'b1);
    chk("to_err_addr", err_addr, 32'h2000_0040);
    chk("to_err_timeout", err_timeout, 1'b1);
    issue(32'h9000_0004);
    drain();
    chk("second_err_addr", err_addr, 32'h2000_0040);
    chk("second_err_timeout", err_timeout, 1'b1);
    pulse_clr();
    chk("clr2_err_valid", err_valid, 1'b0);
    chk("clr2_err_addr", err_addr, 32'h0);
    chk("clr2_err_timeout", err_timeout, 1'b0);

    // Request accepted out of ERR2 straight into a normal read.
    sdata[3] = 32'h5555_AAAA;
    issue(32'h9000_0008);
    issue(32'h5000_0010);
    drain();
    pulse_clr();

    // Fault in the same cycle as the clear wins.
    bus.HREQUEST = 1'b1;
    bus.HADDR    = 32'h1000_0000;
    err_clr      = 1'b1;
    @(posedge HCLK); #1;
    err_clr      = 1'b0;
    bus.HREQUEST = 1'b0;
    chk("clr_race_valid", err_valid, 1'b1);
    chk("clr_race_addr", err_addr, 32'h1000_0000);
    drain();

    // Reset during a slave wait abandons the transfer.
    swaits[0] = 3;
    issue(32'h0000_0200);
    bus.HREQUEST = 1'b0;
    @(negedge HCLK); #2;
    HRESET = 1'b1;
    #1;
    chk("rst_mid_hready", bus.HREADY, 1'b1);
    chk("rst_mid_hresp", bus.HRESP, 1'b0);
    chk("rst_mid_err_valid", err_valid, 1'b0);
    chk("rst_mid_err_addr", err_addr, 32'h0);
    @(negedge HCLK); #2;
    HRESET = 1'b0;
    swaits[0] = 0; sdata[0] = 32'h7777_0001;
    @(posedge HCLK); #1;
    issue(32'h0000_0300);
    drain();
    chk("post_rst_no_fault", err_valid, 1'b0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ahb_lite_fabric.md
AHB_LITE_FABRIC -- requirements
Module: ahb_lite_fabric

Interface
REQ-001 SHALL have parameter NSLV, default 4: number of slave ports (1..8).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum data-phase wait cycles before the fabric aborts the transfer.
REQ-003 SHALL have port HCLK, input, 1: the single clock.
REQ-004 SHALL have port HRESET, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port HREQUEST, input, 1: master address-phase request.
REQ-006 SHALL have ports HADDR (input, 32), HWRITE (input, 1) and HSIZE (input, 3): master address-phase controls.
REQ-007 SHALL have port HRDATA, output, 32: read data returned to the master.
REQ-008 SHALL have ports HREADY (output, 1) and HRESP (output, 1, 1 = ERROR): master-side response.
REQ-009 SHALL have port HSEL_S, output, NSLV: one-hot slave select, valid in the address phase.
REQ-010 SHALL have port HREADY_S, output, 1: the master-side HREADY, broadcast to every slave.
REQ-011 SHALL have ports HREADYOUT_S (input, NSLV), HRESP_S (input, NSLV) and HRDATA_S (input, NSLV x 32): per-slave data-phase responses.
REQ-012 SHALL have port err_valid, output, 1: sticky fault flag.
REQ-013 SHALL have port err_addr, output, 32: address of the first faulting transfer.
REQ-014 SHALL have port err_timeout, output, 1: the latched fault was a timeout (0 = unmapped address).
REQ-015 SHALL have port err_clr, input, 1: clears the fault record.

Function
REQ-016 SHALL decode the address as a match on slave i when (HADDR & MASK[i]) == BASE[i]; lowest index wins on overlap; no match selects the internal default slave.
REQ-017 SHALL drive HSEL_S[i] combinationally as (decode match i) & HREQUEST; all zero otherwise.
REQ-018 SHALL accept an address phase when HREQUEST & HREADY, registering sel_d (slave index or default) and the address.
REQ-019 SHALL implement an FSM with states IDLE, DATA, ERR1 and ERR2.
REQ-020 IDLE: HREADY=1, HRESP=0, HRDATA=0; an accepted mapped request goes to DATA, an accepted unmapped request goes to ERR1.
REQ-021 DATA: HREADY=HREADYOUT_S[sel_d], HRESP=HRESP_S[sel_d], HRDATA=HRDATA_S[sel_d]; on slave ready, a same-cycle accepted request reloads sel_d (DATA or ERR1), otherwise go to IDLE (zero-bubble back-to-back).
REQ-022 SHALL use an 8-bit-minimum wait counter, cleared on entry to DATA and incremented each DATA cycle with slave ready low; when it reaches TIMEOUT, the next state is ERR1 and the slave response is ignored thereafter.
REQ-023 ERR1: HREADY=0, HRESP=1, and the state goes to ERR2.
REQ-024 ERR2: HREADY=1, HRESP=1; it accepts a new request exactly as IDLE does, else goes to IDLE.
REQ-025 SHALL set err_valid on entry to ERR1 from a decode miss or a timeout, latching err_addr/err_timeout only if err_valid was 0 (first fault kept).
REQ-026 err_clr SHALL clear err_valid, err_addr and err_timeout; a fault in the same cycle as err_clr wins (sets and latches).
REQ-027 A slave HRESP=1 SHALL pass through to the master unchanged and SHALL NOT set err_valid.
REQ-028 With TIMEOUT=0, timeout SHALL be disabled (wait indefinitely).

Reset
REQ-029 While HRESET=1, the block SHALL asynchronously set state=IDLE, sel_d=0, counter=0, err_valid=0, err_addr=0, err_timeout=0; outputs take IDLE values (HREADY=1, HRESP=0, HRDATA=0).
REQ-030 Reset mid-transfer SHALL abandon the transfer with no fault recorded.

Structure
REQ-031 Package ahb_fabric_pkg SHALL hold the BASE/MASK address map arrays, the FSM state enum and the response encodings.
REQ-032 Sub-module ahb_fabric_decoder SHALL be purely combinational: HADDR to one-hot plus miss.

Verification
REQ-033 Map slave0 0x0000_0000/0xF000_0000 and slave1 0x2000_0000/0xFFFF_F000; read 0x2000_0010 with slave1 returning 0xDEADBEEF and 0 waits -> HSEL_S=0b0010, HRDATA=0xDEADBEEF the next cycle, HRESP=0.
REQ-034 Back-to-back reads to slave0 then slave1, with slave0 inserting 2 waits -> HREADY low 2 cycles, second address held and accepted on the third cycle, each data returned from the correct slave.
REQ-035 Access to 0x9000_0000 -> HSEL_S=0, HREADY 0 then 1 with HRESP=1 both cycles, err_valid=1, err_addr=0x9000_0000, err_timeout=0.
REQ-036 TIMEOUT=4 and slave1 never ready -> ERR1 after 4 wait cycles, err_timeout=1; a second fault leaves err_addr unchanged; err_clr clears all three.
REQ-037 HRESET pulsed during a slave wait -> HREADY=1 and err_valid=0 immediately, next transfer completes normally.
